// File: rtl/esfa_result_uart_if.sv
// Signal bundle between the ESFA benchmark top level and its result reporter.
// The benchmark side (master) drives the run status and the reporter (slave)
// drives the serial line plus its status flags.
interface esfa_result_uart_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  isRunning;
  logic                  wasSuccessful;
  logic [ADDR_WIDTH-1:0] currentAddr;
  logic                  uart_tx;
  logic                  busy;
  logic                  reportDone;

  modport master (
    output isRunning, wasSuccessful, currentAddr,
    input  uart_tx, busy, reportDone
  );

  modport slave (
    input  isRunning, wasSuccessful, currentAddr,
    output uart_tx, busy, reportDone
  );
endinterface

// File: rtl/esfa_result_uart.sv
// ESFA result reporter: on the falling edge of isRunning, sends one 8N1 line
// over uart_tx, either "PASS\r\n" or "FAIL <hex addr>\r\n". The run result is
// snapshotted at the trigger cycle so later input activity cannot corrupt the
// message in flight. All outputs come straight from flops.
module esfa_result_uart #(
  parameter int CLKS_PER_BIT = 868,
  parameter int ADDR_WIDTH   = 32
) (
  input  logic              clk,
  input  logic              reset,
  esfa_result_uart_if.slave bus
);

  localparam int DIGITS  = ADDR_WIDTH / 4;
  localparam int MSG_MAX = 7 + DIGITS;
  localparam int IDX_W   = $clog2(MSG_MAX + 1);
  localparam int CNT_W   = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_OK   = IDX_W'(5);
  localparam logic [IDX_W-1:0] LAST_FAIL = IDX_W'(MSG_MAX - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Character at position idx of the message selected by ok/addr.
  function automatic logic [7:0] msg_byte(
    input logic [IDX_W-1:0]      idx,
    input logic                  ok,
    input logic [ADDR_WIDTH-1:0] addr
  );
    int                  i;
    logic [ADDR_WIDTH-1:0] tmp;
    logic [3:0]          nib;
    i        = int'(idx);
    tmp      = '0;
    nib      = 4'h0;
    msg_byte = 8'h00;
    if (ok) begin
      case (i)
        0:       msg_byte = 8'h50;
        1:       msg_byte = 8'h41;
        2:       msg_byte = 8'h53;
        3:       msg_byte = 8'h53;
        4:       msg_byte = 8'h0D;
        5:       msg_byte = 8'h0A;
        default: msg_byte = 8'h00;
      endcase
    end else if (i < 5) begin
      case (i)
        0:       msg_byte = 8'h46;
        1:       msg_byte = 8'h41;
        2:       msg_byte = 8'h49;
        3:       msg_byte = 8'h4C;
        4:       msg_byte = 8'h20;
        default: msg_byte = 8'h00;
      endcase
    end else if (i < 5 + DIGITS) begin
      // Most significant nibble first, no leading-zero suppression.
      tmp = addr >> (4 * (DIGITS - 1 - (i - 5)));
      nib = tmp[3:0];
      if (nib < 4'd10) begin
        msg_byte = 8'h30 + {4'h0, nib};
      end else begin
        msg_byte = 8'h37 + {4'h0, nib};
      end
    end else if (i == 5 + DIGITS) begin
      msg_byte = 8'h0D;
    end else if (i == 6 + DIGITS) begin
      msg_byte = 8'h0A;
    end else begin
      msg_byte = 8'h00;
    end
    return msg_byte;
  endfunction

  state_t                state_q, state_d;
  logic                  prev_run_q, prev_run_d;
  logic                  snap_ok_q, snap_ok_d;
  logic [ADDR_WIDTH-1:0] snap_addr_q, snap_addr_d;
  logic [7:0]            shift_q, shift_d;
  logic [CNT_W-1:0]      clk_cnt_q, clk_cnt_d;
  logic [2:0]            bit_idx_q, bit_idx_d;
  logic [IDX_W-1:0]      byte_idx_q, byte_idx_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic                  trigger_s;
  logic                  bit_end_s;
  logic [IDX_W-1:0]      last_idx_s;

  // Trigger detection, bit boundary and message length decode.
  always_comb begin
    trigger_s  = prev_run_q & ~bus.isRunning;
    bit_end_s  = (clk_cnt_q == CNT_MAX);
    last_idx_s = snap_ok_q ? LAST_OK : LAST_FAIL;
  end

  // Next-state and next-output logic for the serialiser FSM.
  always_comb begin
    state_d     = state_q;
    prev_run_d  = bus.isRunning;
    snap_ok_d   = snap_ok_q;
    snap_addr_d = snap_addr_q;
    shift_d     = shift_q;
    clk_cnt_d   = clk_cnt_q;
    bit_idx_d   = bit_idx_q;
    byte_idx_d  = byte_idx_q;
    tx_d        = tx_q;
    busy_d      = busy_q;
    done_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (trigger_s) begin
          state_d     = S_START;
          snap_ok_d   = bus.wasSuccessful;
          snap_addr_d = bus.currentAddr;
          shift_d     = msg_byte({IDX_W{1'b0}}, bus.wasSuccessful, bus.currentAddr);
          clk_cnt_d   = '0;
          bit_idx_d   = 3'd0;
          byte_idx_d  = '0;
          tx_d        = 1'b0;
          busy_d      = 1'b1;
        end else begin
          tx_d   = 1'b1;
          busy_d = 1'b0;
        end
      end

      S_START: begin
        if (bit_end_s) begin
          clk_cnt_d = '0;
          bit_idx_d = 3'd0;
          state_d   = S_DATA;
          tx_d      = shift_q[0];
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end

      S_DATA: begin
        if (bit_end_s) begin
          clk_cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
            tx_d      = shift_q[1];
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end

      S_STOP: begin
        if (bit_end_s) begin
          clk_cnt_d = '0;
          if (byte_idx_q == last_idx_s) begin
            state_d = S_DONE;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            // Back-to-back frames: next start bit follows the stop bit directly.
            byte_idx_d = byte_idx_q + IDX_W'(1);
            shift_d    = msg_byte(byte_idx_q + IDX_W'(1), snap_ok_q, snap_addr_q);
            state_d    = S_START;
            tx_d       = 1'b0;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end

      S_DONE: begin
        // A fall seen here is dropped: the reporter is not idle yet.
        state_d = S_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset parks the line high and drops any message.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      prev_run_q  <= 1'b0;
      snap_ok_q   <= 1'b0;
      snap_addr_q <= '0;
      shift_q     <= 8'h00;
      clk_cnt_q   <= '0;
      bit_idx_q   <= 3'd0;
      byte_idx_q  <= '0;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_run_q  <= prev_run_d;
      snap_ok_q   <= snap_ok_d;
      snap_addr_q <= snap_addr_d;
      shift_q     <= shift_d;
      clk_cnt_q   <= clk_cnt_d;
      bit_idx_q   <= bit_idx_d;
      byte_idx_q  <= byte_idx_d;
      tx_q        <= tx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.uart_tx    = tx_q;
  assign bus.busy       = busy_q;
  assign bus.reportDone = done_q;

endmodule

// File: tb/tb_esfa_result_uart.sv
// Directed bench for esfa_result_uart at CLKS_PER_BIT=4, ADDR_WIDTH=32.
// A line decoder turns uart_tx back into bytes; expected messages and cycle
// positions are written out by hand.
module tb_esfa_result_uart;

  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;

  logic clk = 1'b0;
  logic reset;

  esfa_result_uart_if #(.ADDR_WIDTH(32)) bus_if ();

  esfa_result_uart #(
    .CLKS_PER_BIT(CPB),
    .ADDR_WIDTH  (32)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_if)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // reportDone / busy monitors
  int rd_count = 0;
  int rd_cyc   = -1;
  int busy_cnt = 0;
  always @(negedge clk) begin
    if (bus_if.reportDone === 1'b1) begin
      rd_count <= rd_count + 1;
      rd_cyc   <= cyc;
    end
    if (bus_if.busy === 1'b1) busy_cnt <= busy_cnt + 1;
  end

  // 8N1 decoder, samples mid-bit on the falling clock edge
  logic [7:0] rx_q[$];
  logic       rx_active = 1'b0;
  int         rx_cnt    = 0;
  logic [7:0] rx_byte   = 8'h00;
  always @(negedge clk) begin
    if (reset) begin
      rx_active <= 1'b0;
      rx_cnt    <= 0;
    end else if (!rx_active) begin
      if (bus_if.uart_tx === 1'b0) begin
        rx_active <= 1'b1;
        rx_cnt    <= 0;
      end
    end else begin
      rx_cnt <= rx_cnt + 1;
      if (((rx_cnt + 1) % CPB == 2) && (rx_cnt + 1 >= 6) && (rx_cnt + 1 <= 34))
        rx_byte[(rx_cnt + 1 - 6) / CPB] <= bus_if.uart_tx;
      if (rx_cnt + 1 == 38) begin
        rx_q.push_back(rx_byte);
        rx_active <= 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // mode 0: plain, 1: inputs scrambled right after trigger, 2: extra fall mid-message
  task automatic run_msg(input string tag, input string exp, input logic ok,
                         input logic [31:0] addr, input int mode);
    int t0, rd_base, busy_base, rx_base, n, waited;
    n = exp.len();
    @(negedge clk);
    bus_if.isRunning     = 1'b1;
    bus_if.wasSuccessful = ok;
    bus_if.currentAddr   = addr;
    repeat (3) @(negedge clk);
    rd_base   = rd_count;
    busy_base = busy_cnt;
    rx_base   = rx_q.size();
    bus_if.isRunning = 1'b0;
    @(posedge clk);
    #1;
    t0 = cyc;
    chk({tag, "_busy_at_start"}, {31'd0, bus_if.busy}, 32'd1);
    chk({tag, "_start_bit"}, {31'd0, bus_if.uart_tx}, 32'd0);
    if (mode == 1) begin
      bus_if.wasSuccessful = 1'b1;
      bus_if.currentAddr   = 32'h0000_0000;
    end
    if (mode == 2) begin
      while (cyc < t0 + 100) @(negedge clk);
      bus_if.isRunning = 1'b1;
      while (cyc < t0 + 130) @(negedge clk);
      bus_if.isRunning = 1'b0;
    end
    waited = 0;
    while (rd_count == rd_base && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    chk({tag, "_done_seen"}, {31'd0, rd_count != rd_base}, 32'd1);
    chk({tag, "_done_cycle"}, rd_cyc - t0, n * FRAME);
    repeat ((mode == 2) ? 300 : 20) @(negedge clk);
    chk({tag, "_done_pulses"}, rd_count - rd_base, 32'd1);
    chk({tag, "_busy_cycles"}, busy_cnt - busy_base, n * FRAME);
    chk({tag, "_byte_count"}, rx_q.size() - rx_base, n);
    for (int i = 0; i < n; i++) begin
      if (rx_base + i < rx_q.size())
        chk($sformatf("%s_byte%0d", tag, i), {24'd0, rx_q[rx_base + i]}, {24'd0, exp[i]});
      else
        chk($sformatf("%s_byte%0d_missing", tag, i), 32'd0, 32'd1);
    end
  endtask

  initial begin
    int t0, rd_base, rx_base;
    reset                = 1'b1;
    bus_if.isRunning     = 1'b0;
    bus_if.wasSuccessful = 1'b0;
    bus_if.currentAddr   = 32'h0;
    repeat (3) @(negedge clk);
    chk("reset_tx", {31'd0, bus_if.uart_tx}, 32'd1);
    chk("reset_busy", {31'd0, bus_if.busy}, 32'd0);
    reset = 1'b0;

    // 1: idle after reset with isRunning low
    repeat (200) @(negedge clk);
    chk("idle_tx", {31'd0, bus_if.uart_tx}, 32'd1);
    chk("idle_busy", {31'd0, bus_if.busy}, 32'd0);
    chk("idle_no_done", rd_count, 32'd0);
    chk("idle_no_bytes", rx_q.size(), 32'd0);

    // 2: success
    run_msg("pass", "PASS\r\n", 1'b1, 32'h0, 0);
    // 3: fail at 0xA8, no leading-zero strip
    run_msg("fail_a8", "FAIL 000000A8\r\n", 1'b0, 32'h0000_00A8, 0);
    // 4: snapshot holds across input changes
    run_msg("fail_snap", "FAIL DEADBEEF\r\n", 1'b0, 32'hDEAD_BEEF, 1);
    // 5: second fall mid-message ignored
    run_msg("retrig", "PASS\r\n", 1'b1, 32'h0, 2);

    // 6: reset during DATA of byte 2
    @(negedge clk);
    bus_if.isRunning     = 1'b1;
    bus_if.wasSuccessful = 1'b0;
    bus_if.currentAddr   = 32'h1234_5678;
    repeat (3) @(negedge clk);
    bus_if.isRunning = 1'b0;
    @(posedge clk);
    #1;
    t0 = cyc;
    while (cyc < t0 + 90) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_mid_tx", {31'd0, bus_if.uart_tx}, 32'd1);
    chk("rst_mid_busy", {31'd0, bus_if.busy}, 32'd0);
    chk("rst_mid_done", {31'd0, bus_if.reportDone}, 32'd0);
    repeat (3) @(negedge clk);
    reset   = 1'b0;
    rd_base = rd_count;
    rx_base = rx_q.size();
    repeat (700) @(negedge clk);
    chk("rst_no_done", rd_count - rd_base, 32'd0);
    chk("rst_no_resume", rx_q.size() - rx_base, 32'd0);
    chk("rst_idle_tx", {31'd0, bus_if.uart_tx}, 32'd1);
    run_msg("post_rst", "FAIL 12345678\r\n", 1'b0, 32'h1234_5678, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
